// File: rtl/counter_load_arb_if.sv
// Requester/counter-side bundle for counter_load_arb: two req/val/ack channels plus counter controls.
// Latency: none, this is wiring only.
// Backpressure: req is a level held until ack; nothing is queued while the arbiter is busy.
interface counter_load_arb_if #(
    parameter int WIDTH = 8
);
    logic             req_a;
    logic [WIDTH-1:0] val_a;
    logic             ack_a;
    logic             req_b;
    logic [WIDTH-1:0] val_b;
    logic             ack_b;
    logic             load_en;
    logic [WIDTH-1:0] load_val;
    logic             oe;
    logic             busy;
    logic             last_grant;

    // Requester/observer side: drives requests, watches grants and counter controls
    modport master (
        output req_a, val_a, req_b, val_b,
        input  ack_a, ack_b, load_en, load_val, oe, busy, last_grant
    );

    // Arbiter side
    modport slave (
        input  req_a, val_a, req_b, val_b,
        output ack_a, ack_b, load_en, load_val, oe, busy, last_grant
    );
endinterface

// File: rtl/counter_load_arb.sv
// Round-robin arbiter/sequencer sharing one loadable counter between requesters A and B.
// Latency: req sampled in IDLE -> load_en/ack next cycle, then oe for HOLD_CYCLES cycles.
// Backpressure: requests are only sampled in IDLE; a req seen while busy waits for IDLE.
module counter_load_arb #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    counter_load_arb_if.slave   bus
);
    localparam int CW = (HOLD_CYCLES > 0) ? (($clog2(HOLD_CYCLES + 1) > 0) ? $clog2(HOLD_CYCLES + 1) : 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] hold_cnt;
    logic          win_b;

    // B wins when it is the only requester, or on a tie when A was granted last
    always_comb begin
        win_b = bus.req_b & (~bus.req_a | ~bus.last_grant);
    end

    // Grant sequencing: IDLE -> LOAD (one cycle) -> SHOW (HOLD_CYCLES cycles) -> IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            hold_cnt       <= '0;
            bus.ack_a      <= 1'b0;
            bus.ack_b      <= 1'b0;
            bus.load_en    <= 1'b0;
            bus.load_val   <= '0;
            bus.oe         <= 1'b0;
            bus.busy       <= 1'b0;
            bus.last_grant <= 1'b1;
        end else begin
            bus.ack_a    <= 1'b0;
            bus.ack_b    <= 1'b0;
            bus.load_en  <= 1'b0;
            bus.load_val <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_a | bus.req_b) begin
                        state          <= ST_LOAD;
                        bus.load_en    <= 1'b1;
                        bus.load_val   <= win_b ? bus.val_b : bus.val_a;
                        bus.ack_a      <= ~win_b;
                        bus.ack_b      <= win_b;
                        bus.last_grant <= win_b;
                        bus.busy       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (HOLD_CYCLES == 0) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        state    <= ST_SHOW;
                        bus.oe   <= 1'b1;
                        hold_cnt <= CW'(HOLD_CYCLES - 1);
                    end
                end
                ST_SHOW: begin
                    if (hold_cnt == '0) begin
                        state    <= ST_IDLE;
                        bus.oe   <= 1'b0;
                        bus.busy <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - CW'(1);
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.oe   <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
